// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding,
// default parameter values and the saturating counter increment.
package clk_mon_pkg;

   localparam int N_DEFAULT       = 4;
   localparam int CNT_W_DEFAULT   = 16;
   localparam int TIMEOUT_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [31:0] CNT_SAT(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : (value + 32'd1);
   endfunction

endpackage

// File: rtl/clk_mon_edge_det.sv
// Edge detector for the divided clock: one-cycle delayed copy of div_in
// and combinational rise/fall pulses against it.
module clk_mon_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic div_in,
   output logic rise,
   output logic fall
);

   logic div_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         div_q <= 1'b0;
      else
         div_q <= div_in;
   end

   assign rise = div_in & ~div_q;
   assign fall = ~div_in & div_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period and high time of div_in in clk cycles and
// reports each result over valid/ready. Define CLK_MON_STATS_EN for err/overrun statistics.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int N       = N_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_in,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             ratio_err,
   output logic             timeout,
   output logic [7:0]       err_count,
   output logic [7:0]       overrun_cnt
);

   localparam logic [CNT_W-1:0] N_VAL    = CNT_W'(N);
   localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(N / 2);
   localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] res_period;
   logic [CNT_W-1:0] res_high;
   logic             rise;
   logic             fall;
   logic             stall;
   logic             complete;
   logic             glitch;
   logic             res_err;
   logic             drop;

   clk_mon_edge_det u_edge_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .div_in (div_in),
      .rise   (rise),
      .fall   (fall)
   );

   assign cnt_inc = CNT_W'(CNT_SAT(32'(cnt), CNT_W));
   assign stall   = (cnt_inc == TO_VAL);
   assign drop    = complete & meas_valid & ~meas_ready;

   // A rise closes the period; seen in HIGH it means the fall went missing.
   always_comb begin
      complete   = 1'b0;
      glitch     = 1'b0;
      res_period = cnt;
      res_high   = hi;
      if (en && rise) begin
         if (state == HIGH) begin
            complete = 1'b1;
            glitch   = 1'b1;
            res_high = cnt;
         end else if (state == LOW) begin
            complete = 1'b1;
         end
      end
      res_err = glitch | (res_period != N_VAL) | (res_high != HALF_VAL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         hi          <= '0;
         timeout     <= 1'b0;
         meas_valid  <= 1'b0;
         meas_period <= '0;
         meas_high   <= '0;
         ratio_err   <= 1'b0;
      end else begin
         if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            timeout <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= SYNC;
                  cnt   <= '0;
                  hi    <= '0;
               end
               SYNC: begin
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= ONE;
                  end else if (stall) begin
                     timeout <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               HIGH: begin
                  if (rise) begin
                     cnt <= ONE;
                  end else if (fall) begin
                     hi    <= cnt;
                     state <= LOW;
                     cnt   <= cnt_inc;
                  end else if (stall) begin
                     timeout <= 1'b1;
                     state   <= SYNC;
                     cnt     <= '0;
                     hi      <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               LOW: begin
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= ONE;
                  end else if (stall) begin
                     timeout <= 1'b1;
                     state   <= SYNC;
                     cnt     <= '0;
                     hi      <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // An accept in the completion cycle frees the slot, so nothing is dropped.
         if (complete && !drop) begin
            meas_valid  <= 1'b1;
            meas_period <= res_period;
            meas_high   <= res_high;
            ratio_err   <= res_err;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

`ifdef CLK_MON_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count   <= '0;
         overrun_cnt <= '0;
      end else begin
         if (complete && res_err)
            err_count <= 8'(CNT_SAT(32'(err_count), 8));
         if (drop)
            overrun_cnt <= 8'(CNT_SAT(32'(overrun_cnt), 8));
      end
   end
`else
   assign err_count   = '0;
   assign overrun_cnt = '0;
`endif

endmodule
